// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx serializer between two byte producers.
// Each channel writes into its own FIFO. A round-robin FSM pops one byte at a
// time and drives the serializer's start-pulse/byte handshake.
//
// Optional feature macro: UART_ARB_TAG_EN. When it is defined, every grant sends
// the tag byte (TAG_BASE | channel) followed by the data byte.
//
// Ports:
//   clk        system clock; all logic runs on its posedge
//   reset      synchronous, active-high reset
//   req0_dv    channel 0 write strobe; req0_d is the channel 0 data byte
//   req1_dv    channel 1 write strobe; req1_d is the channel 1 data byte
//   ovf        sticky per-channel overflow flags (bit n = channel n)
//   tx_dv      one-cycle start pulse to uart_tx i_TX_DV
//   tx_d       byte to uart_tx i_TX_Byte, held until the next pulse
//   tx_active  uart_tx o_TX_Active
//   busy       FSM not idle, or either FIFO not empty
module uart_tx_arbiter #(
    parameter int unsigned ADDR_W   = 7,
    parameter logic [7:0]  TAG_BASE = 8'hF0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_dv,
    input  logic [7:0] req0_d,
    input  logic       req1_dv,
    input  logic [7:0] req1_d,
    output logic [1:0] ovf,
    output logic       tx_dv,
    output logic [7:0] tx_d,
    input  logic       tx_active,
    output logic       busy
);

    localparam int unsigned Depth  = 1 << ADDR_W;
    localparam logic [ADDR_W:0] PtrOne = 1;

`ifdef UART_ARB_TAG_EN
    typedef enum logic [2:0] {
        StIdle, StTagIssue, StTagWaitStart, StTagWaitEnd, StIssue, StWaitStart, StWaitEnd
    } state_e;
`else
    typedef enum logic [1:0] {StIdle, StIssue, StWaitStart, StWaitEnd} state_e;
`endif

    state_e state_q, state_d;

    logic [7:0] mem0 [Depth];
    logic [7:0] mem1 [Depth];

    logic [ADDR_W:0] wr0_q, wr0_d, rd0_q, rd0_d;
    logic [ADDR_W:0] wr1_q, wr1_d, rd1_q, rd1_d;
    logic [1:0]      ovf_q, ovf_d;
    logic            grant_q, grant_d;
    logic            last_q, last_d;
    logic            tx_dv_q, tx_dv_d;
    logic [7:0]      tx_d_q, tx_d_d;

    logic empty0, empty1, full0, full1;
    logic [7:0] head;

    assign empty0 = (wr0_q == rd0_q);
    assign empty1 = (wr1_q == rd1_q);
    assign full0  = (wr0_q[ADDR_W] != rd0_q[ADDR_W]) &&
                    (wr0_q[ADDR_W-1:0] == rd0_q[ADDR_W-1:0]);
    assign full1  = (wr1_q[ADDR_W] != rd1_q[ADDR_W]) &&
                    (wr1_q[ADDR_W-1:0] == rd1_q[ADDR_W-1:0]);

    assign head = grant_q ? mem1[rd1_q[ADDR_W-1:0]] : mem0[rd0_q[ADDR_W-1:0]];

    // RAM contents are deliberately left untouched by reset.
    always_ff @(posedge clk) begin
        if (req0_dv && !full0) mem0[wr0_q[ADDR_W-1:0]] <= req0_d;
        if (req1_dv && !full1) mem1[wr1_q[ADDR_W-1:0]] <= req1_d;
    end

    // Write side; full uses registered pointers so a same-cycle pop never frees room.
    always_comb begin
        wr0_d = wr0_q;
        wr1_d = wr1_q;
        ovf_d = ovf_q;
        if (req0_dv) begin
            if (full0) ovf_d[0] = 1'b1;
            else       wr0_d    = wr0_q + PtrOne;
        end
        if (req1_dv) begin
            if (full1) ovf_d[1] = 1'b1;
            else       wr1_d    = wr1_q + PtrOne;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        tx_dv_d = 1'b0;
        tx_d_d  = tx_d_q;
        case (state_q)
            StIdle: begin
                if (!tx_active && (!empty0 || !empty1)) begin
                    // Both pending: take the one not granted last; else the pending one.
                    grant_d = (!empty0 && !empty1) ? ~last_q : !empty1;
`ifdef UART_ARB_TAG_EN
                    state_d = StTagIssue;
`else
                    state_d = StIssue;
`endif
                end
            end
`ifdef UART_ARB_TAG_EN
            StTagIssue: begin
                tx_d_d  = TAG_BASE | {7'd0, grant_q};
                tx_dv_d = 1'b1;
                state_d = StTagWaitStart;
            end
            StTagWaitStart: if (tx_active) state_d = StTagWaitEnd;
            StTagWaitEnd:   if (!tx_active) state_d = StIssue;
`endif
            StIssue: begin
                tx_d_d  = head;
                tx_dv_d = 1'b1;
                last_d  = grant_q;
                if (grant_q) rd1_d = rd1_q + PtrOne;
                else         rd0_d = rd0_q + PtrOne;
                state_d = StWaitStart;
            end
            StWaitStart: if (tx_active) state_d = StWaitEnd;
            StWaitEnd:   if (!tx_active) state_d = StIdle;
            default:     state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            tx_dv_q <= 1'b0;
            tx_d_q  <= 8'd0;
            ovf_q   <= 2'b00;
            wr0_q   <= '0;
            rd0_q   <= '0;
            wr1_q   <= '0;
            rd1_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            tx_dv_q <= tx_dv_d;
            tx_d_q  <= tx_d_d;
            ovf_q   <= ovf_d;
            wr0_q   <= wr0_d;
            rd0_q   <= rd0_d;
            wr1_q   <= wr1_d;
            rd1_q   <= rd1_d;
        end
    end

    assign tx_dv = tx_dv_q;
    assign tx_d  = tx_d_q;
    assign ovf   = ovf_q;
    assign busy  = (state_q != StIdle) || !empty0 || !empty1;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx serializer between two byte producers, e.g. two MIIcore receive channels (mii0, mii1).
- Each requester pushes bytes into its own internal FIFO.
- A round-robin scheduler pops one byte at a time and drives the serializer's i_TX_DV / i_TX_Byte handshake.
- Sits between the MII capture logic and uart_tx in the top level, replacing ad-hoc single-channel FIFO glue.

Parameters:
- ADDR_W, 7, log2 of per-channel FIFO depth (default depth 128 bytes).
- TAG_BASE, 8'hF0, tag byte base value, used only when UART_ARB_TAG_EN is defined.

Ports:
- clk  input  1  system clock; all logic is on its posedge.
- reset  input  1  synchronous, active-high reset.
- req0_dv  input  1  one-cycle write strobe for channel 0.
- req0_d  input  8  channel 0 data byte, sampled when req0_dv=1.
- req1_dv  input  1  one-cycle write strobe for channel 1.
- req1_d  input  8  channel 1 data byte.
- ovf  output  2  sticky per-channel overflow flags, bit n = channel n.
- tx_dv  output  1  one-cycle start pulse to uart_tx i_TX_DV.
- tx_d  output  8  byte to uart_tx i_TX_Byte; held stable from the pulse until the next pulse.
- tx_active  input  1  uart_tx o_TX_Active.
- busy  output  1  high when the FSM is not in IDLE or either FIFO is non-empty.

Behaviour:
- Reset (synchronous, 1 cycle) clears all pointers, ovf=0, tx_dv=0, tx_d=0, FSM=IDLE and the round-robin last-grant register to 1, so channel 0 wins first. FIFO RAM contents are not cleared.
- FIFOs: one per channel; read and write pointers are ADDR_W+1 bits.
  - empty when pointers are equal.
  - full when the MSBs differ and the low bits are equal.
  - Pointers wrap modulo 2^(ADDR_W+1).
- Write: if req_dv=1 and not full, store the byte and increment the write pointer next cycle. If full, drop the byte and set ovf[n]=1. The flag stays set until reset.
- Full is evaluated before any same-cycle pop, so a write to a full FIFO is dropped even if a pop occurs that cycle.
- Simultaneous writes to both channels are independent and are both accepted.
- FSM:
  - IDLE: if tx_active=0 and any FIFO is non-empty, grant the non-empty channel not equal to last-grant. If only one channel is non-empty, grant it. Go to ISSUE.
  - ISSUE (1 cycle): tx_d <= fifo[grant][rd]; increment rd; tx_dv <= 1; update last-grant; go to WAIT_START.
  - WAIT_START: tx_dv <= 0; stay until tx_active=1, then go to WAIT_END.
  - WAIT_END: stay until tx_active=0, then go to IDLE.
- Timing:
  - tx_dv is high exactly one cycle per byte and never while tx_active=1.
  - Minimum FIFO-write-to-tx_dv latency is 3 cycles: write, IDLE decision, ISSUE register.
  - Back-to-back bytes have at least 1 IDLE cycle between tx_active falling and the next tx_dv.
- Fairness: with both FIFOs continuously non-empty, the output strictly alternates 0,1,0,1.
- A reset asserted mid-transfer returns the FSM to IDLE and empties both FIFOs. The uart_tx byte already started completes on its own; the arbiter waits for tx_active=0 in IDLE before issuing again.

Optional Feature:
- Macro: UART_ARB_TAG_EN.
- Defined: each grant sends two bytes. The first is the tag TAG_BASE|channel (8'hF0 or 8'hF1), then the data byte.
  - Added states TAG_ISSUE, TAG_WAIT_START and TAG_WAIT_END precede ISSUE and follow the same handshake rules.
  - The data byte is popped only in ISSUE.
  - Round-robin advances per pair, so a tag is never separated from its data byte.
- Undefined: only data bytes are sent, with no extra states or logic.

Test Plan:
- Single byte: reset, then req0_d=8'h55 pulse. Expect one tx_dv with tx_d=8'h55 three cycles later, busy low after tx_active falls, ovf=2'b00.
- Contention: preload ch0 with A0,A1,A2 and ch1 with B0,B1,B2 in the same cycles, using a uart_tx model with 10-cycle active. Expect output order A0,B0,A1,B1,A2,B2.
- Overflow: with ADDR_W=2 and a stalled tx (tx_active held 1), write 5 bytes 01..05 to ch1. Expect ovf=2'b10, and after release exactly 01..04 are sent.
- Pointer wrap: with ADDR_W=2, stream 20 bytes 00..13 on ch0 at one per transfer. Expect all 20 sent in order and no ovf.
- Reset mid-operation: assert reset during WAIT_END with 3 bytes queued. Expect no tx_dv until reset is released and tx_active=0, then no further output, empty FIFOs, ovf=0.
- Tag mode (UART_ARB_TAG_EN): ch1 byte 8'h3C. Expect tx_d sequence F1,3C, each with its own tx_dv pulse.
